// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the two requester ports (pipeline P, debug D) and the data-memory
// side of dmem_port_arbiter.
//   P / D   : Req, We, Addr, WData in; Ack, RData out (P also gets Stall)
//   status  : O_AddrErr, pulses with the Ack of an illegal-address access
//   memory  : O_MemEn/O_MemWe/O_MemAddr/O_MemWData out, I_MemRData in
// Modports:
//   slave   - the arbiter itself
//   master  - the environment (requesters plus memory array)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              I_P_Req;
  logic              I_P_We;
  logic [ADDR_W-1:0] I_P_Addr;
  logic [DATA_W-1:0] I_P_WData;
  logic              O_P_Ack;
  logic [DATA_W-1:0] O_P_RData;
  logic              O_P_Stall;

  logic              I_D_Req;
  logic              I_D_We;
  logic [ADDR_W-1:0] I_D_Addr;
  logic [DATA_W-1:0] I_D_WData;
  logic              O_D_Ack;
  logic [DATA_W-1:0] O_D_RData;

  logic              O_AddrErr;
  logic              O_MemEn;
  logic              O_MemWe;
  logic [ADDR_W-1:0] O_MemAddr;
  logic [DATA_W-1:0] O_MemWData;
  logic [DATA_W-1:0] I_MemRData;

  modport slave (
    input  I_P_Req, I_P_We, I_P_Addr, I_P_WData,
    input  I_D_Req, I_D_We, I_D_Addr, I_D_WData,
    input  I_MemRData,
    output O_P_Ack, O_P_RData, O_P_Stall,
    output O_D_Ack, O_D_RData,
    output O_AddrErr, O_MemEn, O_MemWe, O_MemAddr, O_MemWData
  );

  modport master (
    output I_P_Req, I_P_We, I_P_Addr, I_P_WData,
    output I_D_Req, I_D_We, I_D_Addr, I_D_WData,
    output I_MemRData,
    input  O_P_Ack, O_P_RData, O_P_Stall,
    input  O_D_Ack, O_D_RData,
    input  O_AddrErr, O_MemEn, O_MemWe, O_MemAddr, O_MemWData
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one single-port data memory between the pipeline memory stage (P)
// and a debug/loader port (D). One access at a time: IDLE -> ISSUE ->
// [WAIT for MEM_LAT cycles on legal reads] -> RESP -> IDLE.
// P has priority, but D is forced through once it has lost STARVE_MAX
// contested arbitrations. All state changes on the falling clock edge.
// Ports:
//   I_CLOCK : clock, falling edge active
//   I_LOCK  : asynchronous active-low reset
//   bus     : dmem_port_arbiter_if.slave (requester ports + memory side)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 10,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int          MEM_LAT    = 2,
  parameter int          STARVE_MAX = 4
) (
  input logic                I_CLOCK,
  input logic                I_LOCK,
  dmem_port_arbiter_if.slave bus
);

  localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_owner_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [STV_W-1:0]  r_starve;
  logic [DATA_W-1:0] r_p_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_any_req;
  logic              w_gnt_d;
  logic              w_addr_bad;
  logic              w_lat_done;

  logic              w_p_ack;
  logic              w_d_ack;
  logic              w_addr_err;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_any_req  = bus.I_P_Req | bus.I_D_Req;
  // D wins when alone, or when contested and it has already lost STARVE_MAX times.
  assign w_gnt_d    = bus.I_D_Req & (~bus.I_P_Req | (r_starve == STV_MAX));
  // Widen to 32 bits so a depth equal to 2**ADDR_W compares correctly.
  assign w_addr_bad = (32'(r_addr) >= MEM_DEPTH);
  // The counter hits zero on the edge where it is currently 1.
  assign w_lat_done = (r_lat_cnt <= LAT_W'(1));

  // FSM state register
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next_state = ST_ISSUE;
        else           w_next_state = ST_IDLE;
      end
      ST_ISSUE: begin
        if (r_we || w_addr_bad) w_next_state = ST_RESP;
        else                    w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_lat_done) w_next_state = ST_RESP;
        else            w_next_state = ST_WAIT;
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Grant capture, error flag, latency/starvation counters and read-data registers
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_lat_cnt <= '0;
      r_starve  <= '0;
      r_p_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_gnt_d;
            r_we      <= w_gnt_d ? bus.I_D_We    : bus.I_P_We;
            r_addr    <= w_gnt_d ? bus.I_D_Addr  : bus.I_P_Addr;
            r_wdata   <= w_gnt_d ? bus.I_D_WData : bus.I_P_WData;
            r_err     <= 1'b0;
          end
          if (w_gnt_d) begin
            r_starve <= '0;
          end else if (bus.I_P_Req && bus.I_D_Req && (r_starve != STV_MAX)) begin
            r_starve <= r_starve + STV_W'(1);
          end
        end
        ST_ISSUE: begin
          r_err <= w_addr_bad;
          if (!r_we && !w_addr_bad) begin
            r_lat_cnt <= LAT_LOAD;
          end
        end
        ST_WAIT: begin
          r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          if (w_lat_done) begin
            if (r_owner_d) r_d_rdata <= bus.I_MemRData;
            else           r_p_rdata <= bus.I_MemRData;
          end
        end
        ST_RESP: begin
          // Read data is only presented alongside Ack; clear it on the way out.
          r_p_rdata <= '0;
          r_d_rdata <= '0;
        end
        default: begin
          r_lat_cnt <= '0;
        end
      endcase
    end
  end

  // FSM outputs: memory strobe in ISSUE, owner's Ack/error in RESP
  always_comb begin
    w_p_ack     = 1'b0;
    w_d_ack     = 1'b0;
    w_addr_err  = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_ISSUE: begin
        if (!w_addr_bad) begin
          w_mem_en    = 1'b1;
          w_mem_we    = r_we;
          w_mem_addr  = r_addr;
          w_mem_wdata = r_wdata;
        end else begin
          w_mem_en    = 1'b0;
          w_mem_we    = 1'b0;
        end
      end
      ST_RESP: begin
        w_p_ack    = ~r_owner_d;
        w_d_ack    = r_owner_d;
        w_addr_err = r_err;
      end
      default: begin
        w_mem_en = 1'b0;
      end
    endcase
  end

  assign bus.O_P_Ack    = w_p_ack;
  assign bus.O_D_Ack    = w_d_ack;
  assign bus.O_P_RData  = r_p_rdata;
  assign bus.O_D_RData  = r_d_rdata;
  assign bus.O_AddrErr  = w_addr_err;
  assign bus.O_MemEn    = w_mem_en;
  assign bus.O_MemWe    = w_mem_we;
  assign bus.O_MemAddr  = w_mem_addr;
  assign bus.O_MemWData = w_mem_wdata;
  assign bus.O_P_Stall  = bus.I_P_Req & ~w_p_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Self-checking bench for dmem_port_arbiter. ADDR_W is 11 so that addresses
// at and above MEM_DEPTH=1024 can be presented. The DUT acts on falling
// edges; the bench drives and samples around rising edges (mid-cycle).
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int SMAX  = 4;
  localparam int NWORD = 1 << AW;

  logic I_CLOCK;
  logic I_LOCK;

  dmem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .I_CLOCK(I_CLOCK),
    .I_LOCK (I_LOCK),
    .bus    (bus)
  );

  initial begin
    I_CLOCK = 1'b1;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  function automatic logic [DW-1:0] pat(input int i);
    pat = DW'(i * 32'h1357) ^ 16'hA5A5;
  endfunction

  // Memory array seen by the DUT: registered read, data held until next read.
  logic [DW-1:0] pmem [0:NWORD-1];
  logic [DW-1:0] pmem_rd;
  logic          mem_init;

  always @(negedge I_CLOCK) begin
    if (mem_init) begin
      for (int i = 0; i < NWORD; i++) pmem[i] <= pat(i);
      pmem_rd <= '0;
    end else if (bus.O_MemEn) begin
      if (bus.O_MemWe) pmem[bus.O_MemAddr] <= bus.O_MemWData;
      else             pmem_rd <= pmem[bus.O_MemAddr];
    end
  end
  assign bus.I_MemRData = pmem_rd;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_p(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.I_P_Req = req; bus.I_P_We = we; bus.I_P_Addr = a; bus.I_P_WData = d;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.I_D_Req = req; bus.I_D_We = we; bus.I_D_Addr = a; bus.I_D_WData = d;
  endtask

  typedef struct {
    bit            port_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            chg_at;    // cycle at which the requester changes Addr (-1: never)
    logic [AW-1:0] chg_addr;
    int            lat;       // expected Ack cycle
    logic [DW-1:0] rd;
    bit            err;
    bit            en;        // expect one memory strobe in cycle 1
  } vec_t;

  // One isolated access, measured from the IDLE cycle where Req first appears.
  task automatic run_vec(input vec_t v, input int idx);
    int c, lat, en_n, en_cyc, bad_stall, bad_other;
    bit done, err, en_we;
    logic [DW-1:0] rd;
    logic [AW-1:0] en_addr;
    c = 0; lat = -1; en_n = 0; en_cyc = -1; bad_stall = 0; bad_other = 0;
    done = 1'b0; err = 1'b0; en_we = 1'b0; rd = '0; en_addr = '0;
    @(posedge I_CLOCK);
    if (v.port_d) set_d(1'b1, v.we, v.addr, v.wd);
    else          set_p(1'b1, v.we, v.addr, v.wd);
    while (!done && c < 40) begin
      #1;
      if (bus.O_MemEn === 1'b1) begin
        en_n++; en_cyc = c; en_addr = bus.O_MemAddr; en_we = bus.O_MemWe;
      end
      if (bus.O_P_Stall !== ((!v.port_d) && (c != v.lat))) bad_stall++;
      if ((v.port_d ? bus.O_P_Ack : bus.O_D_Ack) !== 1'b0) bad_other++;
      if ((v.port_d ? bus.O_D_Ack : bus.O_P_Ack) === 1'b1) begin
        done = 1'b1; lat = c; err = bus.O_AddrErr;
        rd = v.port_d ? bus.O_D_RData : bus.O_P_RData;
      end
      if (v.chg_at == c) begin
        if (v.port_d) bus.I_D_Addr = v.chg_addr;
        else          bus.I_P_Addr = v.chg_addr;
      end
      @(posedge I_CLOCK);
      c++;
    end
    set_p(1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    chk($sformatf("vec%0d ack_cycle", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("vec%0d rdata", idx), 32'(rd), 32'(v.rd));
    chk($sformatf("vec%0d addr_err", idx), 32'(err), 32'(v.err));
    chk($sformatf("vec%0d mem_strobes", idx), 32'(en_n), v.en ? 32'd1 : 32'd0);
    chk($sformatf("vec%0d stall_profile", idx), 32'(bad_stall), 32'd0);
    chk($sformatf("vec%0d other_ack", idx), 32'(bad_other), 32'd0);
    if (v.en) begin
      chk($sformatf("vec%0d strobe_cycle", idx), 32'(en_cyc), 32'd1);
      chk($sformatf("vec%0d strobe_addr", idx), 32'(en_addr), 32'(v.addr));
      chk($sformatf("vec%0d strobe_we", idx), 32'(en_we), 32'(v.we));
    end
  endtask

  // Reference model state for the randomized phase.
  logic [DW-1:0] ref_mem [0:NWORD-1];
  bit            m_busy, m_own_d, m_bad, m_we;
  int            m_start, m_ack, m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) rnd_addr = AW'(DEPTH + $urandom_range(0, DEPTH - 1));
    else                           rnd_addr = AW'($urandom_range(0, 15));
  endfunction

  vec_t vecs [0:10];
  int   order [0:10];

  initial begin
    int n, c;
    bit p_new, d_new;
    bit e_pack, e_dack, e_err, e_en, e_stall;
    logic [DW-1:0] e_prd, e_drd;

    n_cmp = 0; n_bad = 0;
    I_LOCK = 1'b0; mem_init = 1'b1;
    set_p(1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, '0, '0);

    // ---- reset state ----
    @(posedge I_CLOCK);
    bus.I_P_Req = 1'b1;
    #1;
    chk("rst ctrl_outs", 32'({bus.O_P_Ack, bus.O_D_Ack, bus.O_AddrErr, bus.O_MemEn, bus.O_MemWe}), 32'd0);
    chk("rst rdata", {bus.O_P_RData, bus.O_D_RData}, 32'd0);
    chk("rst mem_bus", 32'(bus.O_MemAddr) | 32'(bus.O_MemWData), 32'd0);
    chk("rst stall_follows_req_hi", 32'(bus.O_P_Stall), 32'd1);
    bus.I_P_Req = 1'b0;
    #1;
    chk("rst stall_follows_req_lo", 32'(bus.O_P_Stall), 32'd0);
    @(posedge I_CLOCK);
    mem_init = 1'b0; I_LOCK = 1'b1;

    // ---- table-driven single accesses ----
    //          port  we    addr     wd        chg  chg_addr lat rd        err  en
    vecs[0]  = '{1'b0, 1'b1, 11'h010, 16'h3A5C, -1, 11'h000, 2,  16'h0000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 11'h010, 16'h0000, -1, 11'h000, 4,  16'h3A5C, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 11'h400, 16'h0000, -1, 11'h000, 2,  16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 11'h3FF, 16'hBEEF, -1, 11'h000, 2,  16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 11'h3FF, 16'h0000, -1, 11'h000, 4,  16'hBEEF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 11'h7FF, 16'h1234, -1, 11'h000, 2,  16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 11'h010, 16'h0000, -1, 11'h000, 4,  16'h3A5C, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 11'h3FF, 16'h0000,  2, 11'h010, 4,  16'hBEEF, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 11'h005, 16'h0000, -1, 11'h000, 2,  16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 11'h005, 16'h0000, -1, 11'h000, 4,  16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 11'h7FF, 16'h0000, -1, 11'h000, 2,  16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // ---- starvation: both ports write continuously ----
    for (int i = 0; i < 11; i++) order[i] = 2;
    @(posedge I_CLOCK);
    set_p(1'b1, 1'b1, 11'h020, 16'h1000);
    set_d(1'b1, 1'b1, 11'h030, 16'h2000);
    n = 0; c = 0;
    while (n < 11 && c < 200) begin
      #1;
      if (bus.O_P_Ack === 1'b1) begin order[n] = 0; n++; bus.I_P_WData = bus.I_P_WData + 16'd1; end
      if (bus.O_D_Ack === 1'b1 && n < 11) begin order[n] = 1; n++; bus.I_D_WData = bus.I_D_WData + 16'd1; end
      @(posedge I_CLOCK);
      c++;
    end
    set_p(1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    chk("starve grant_count", 32'(n), 32'd11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("starve grant%0d_is_d", i), 32'(order[i]), ((i + 1) % (SMAX + 1) == 0) ? 32'd1 : 32'd0);

    // ---- reset during WAIT of a P read, then a fresh read ----
    @(posedge I_CLOCK);
    set_p(1'b1, 1'b0, 11'h010, 16'h0000);
    repeat (2) @(posedge I_CLOCK);
    I_LOCK = 1'b0;
    #1;
    chk("lock ctrl_outs", 32'({bus.O_P_Ack, bus.O_D_Ack, bus.O_AddrErr, bus.O_MemEn, bus.O_MemWe}), 32'd0);
    chk("lock rdata", {bus.O_P_RData, bus.O_D_RData}, 32'd0);
    chk("lock stall", 32'(bus.O_P_Stall), 32'd1);
    @(posedge I_CLOCK);
    #1;
    chk("lock no_ack", 32'({bus.O_P_Ack, bus.O_D_Ack}), 32'd0);
    I_LOCK = 1'b1;
    c = 0; n = -1;
    while (n < 0 && c < 30) begin
      if (bus.O_P_Ack === 1'b1) begin n = c; e_prd = bus.O_P_RData; end
      @(posedge I_CLOCK);
      #1;
      c++;
    end
    set_p(1'b0, 1'b0, '0, '0);
    chk("lock fresh_ack_cycle", 32'(n), 32'(2 + LAT));
    chk("lock fresh_rdata", 32'(e_prd), 32'h3A5C);

    // ---- randomized traffic against the transaction-level model ----
    @(posedge I_CLOCK);
    I_LOCK = 1'b0; mem_init = 1'b1;
    repeat (2) @(posedge I_CLOCK);
    mem_init = 1'b0; I_LOCK = 1'b1;
    for (int i = 0; i < NWORD; i++) ref_mem[i] = pat(i);
    m_busy = 1'b0; m_starve = 0; m_start = 0; m_ack = 0;
    m_own_d = 1'b0; m_bad = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge I_CLOCK);
      // Requesters: on Ack either drop Req or chain a new access.
      p_new = 1'b0; d_new = 1'b0;
      if (bus.O_P_Ack === 1'b1) begin
        if ($urandom_range(0, 1) == 1) p_new = 1'b1; else set_p(1'b0, 1'b0, '0, '0);
      end else if (!bus.I_P_Req && $urandom_range(0, 2) == 0) p_new = 1'b1;
      if (bus.O_D_Ack === 1'b1) begin
        if ($urandom_range(0, 1) == 1) d_new = 1'b1; else set_d(1'b0, 1'b0, '0, '0);
      end else if (!bus.I_D_Req && $urandom_range(0, 3) == 0) d_new = 1'b1;
      if (p_new) set_p(1'b1, 1'($urandom_range(0, 1)), rnd_addr(), DW'($urandom));
      if (d_new) set_d(1'b1, 1'($urandom_range(0, 1)), rnd_addr(), DW'($urandom));
      #1;
      e_pack  = m_busy && (cyc == m_ack) && !m_own_d;
      e_dack  = m_busy && (cyc == m_ack) &&  m_own_d;
      e_err   = m_busy && (cyc == m_ack) &&  m_bad;
      e_prd   = e_pack ? m_rd : '0;
      e_drd   = e_dack ? m_rd : '0;
      e_en    = m_busy && (cyc == m_start + 1) && !m_bad;
      e_stall = bus.I_P_Req && !e_pack;
      chk("rnd p_ack",   32'(bus.O_P_Ack),   32'(e_pack));
      chk("rnd d_ack",   32'(bus.O_D_Ack),   32'(e_dack));
      chk("rnd p_rdata", 32'(bus.O_P_RData), 32'(e_prd));
      chk("rnd d_rdata", 32'(bus.O_D_RData), 32'(e_drd));
      chk("rnd addr_err", 32'(bus.O_AddrErr), 32'(e_err));
      chk("rnd mem_en",  32'(bus.O_MemEn),   32'(e_en));
      chk("rnd stall",   32'(bus.O_P_Stall), 32'(e_stall));
      if (e_en) begin
        chk("rnd mem_we",   32'(bus.O_MemWe),   32'(m_we));
        chk("rnd mem_addr", 32'(bus.O_MemAddr), 32'(m_addr));
        if (m_we) chk("rnd mem_wdata", 32'(bus.O_MemWData), 32'(m_wd));
      end
      // Advance the model: one access at a time, next grant after the Ack cycle.
      if (m_busy) begin
        if (cyc == m_ack) m_busy = 1'b0;
      end else if (bus.I_P_Req || bus.I_D_Req) begin
        if (bus.I_P_Req && bus.I_D_Req) begin
          m_own_d = (m_starve == SMAX);
          m_starve = m_own_d ? 0 : ((m_starve < SMAX) ? m_starve + 1 : SMAX);
        end else begin
          m_own_d = bus.I_D_Req;
          if (m_own_d) m_starve = 0;
        end
        m_we    = m_own_d ? bus.I_D_We    : bus.I_P_We;
        m_addr  = m_own_d ? bus.I_D_Addr  : bus.I_P_Addr;
        m_wd    = m_own_d ? bus.I_D_WData : bus.I_P_WData;
        m_bad   = (int'(m_addr) >= DEPTH);
        m_rd    = (m_we || m_bad) ? '0 : ref_mem[m_addr];
        if (m_we && !m_bad) ref_mem[m_addr] = m_wd;
        m_start = cyc;
        m_ack   = cyc + ((m_we || m_bad) ? 2 : 2 + LAT);
        m_busy  = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one single-port data memory between two requesters: the pipeline memory stage (port P) and a debug/loader port (port D).
- Serialises accesses and models memory latency with a fixed-latency read path.
- Stalls the pipeline while its access is pending.
- Bounds debug-port starvation with an age counter.
- Sits between the memory stage and the data memory array.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 10, word address width.
- MEM_DEPTH, 1024, number of valid words; addresses >= MEM_DEPTH are illegal.
- MEM_LAT, 2, read latency in cycles from the issue cycle to data valid (minimum 1).
- STARVE_MAX, 4, losing cycles after which port D gets forced priority.

Ports:
- I_CLOCK  in  1  clock; all state updates on the falling edge.
- I_LOCK  in  1  asynchronous active-low reset.
- I_P_Req  in  1  pipeline request; level, held until O_P_Ack.
- I_P_We  in  1  pipeline write enable (1 = store).
- I_P_Addr  in  ADDR_W  pipeline word address.
- I_P_WData  in  DATA_W  pipeline store data.
- O_P_Ack  out  1  one-cycle completion pulse for port P.
- O_P_RData  out  DATA_W  read data for port P, valid while O_P_Ack=1.
- O_P_Stall  out  1  pipeline stall; combinational, I_P_Req & ~O_P_Ack.
- I_D_Req, I_D_We, I_D_Addr, I_D_WData  in  1/1/ADDR_W/DATA_W  debug request, same rules as port P.
- O_D_Ack  out  1  one-cycle completion pulse for port D.
- O_D_RData  out  DATA_W  read data for port D, valid while O_D_Ack=1.
- O_AddrErr  out  1  pulses with Ack when the completed access had an illegal address.
- O_MemEn  out  1  memory access strobe, one cycle per access.
- O_MemWe  out  1  memory write enable, qualified by O_MemEn.
- O_MemAddr  out  ADDR_W  memory address.
- O_MemWData  out  DATA_W  memory write data.
- I_MemRData  in  DATA_W  memory read data.

Behaviour:
- Reset (I_LOCK=0, asynchronous):
  - FSM goes to IDLE; latency and starvation counters clear to 0.
  - All outputs 0: Acks, RData, AddrErr, MemEn, MemWe, MemAddr, MemWData.
  - O_P_Stall follows I_P_Req.
  - An in-flight access is abandoned with no Ack. A write already strobed may or may not have landed.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant P, unless the starvation count equals STARVE_MAX; then grant D.
  - On a grant, capture owner, We, Addr and WData into registers, then go to ISSUE.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each IDLE arbitration in which D requests and P wins.
  - Clears when D is granted.
- ISSUE (one cycle):
  - Legal address: O_MemEn=1, with O_MemWe/O_MemAddr/O_MemWData from the captured registers.
  - Illegal address: O_MemEn=0 and the error flag is set.
  - Write or illegal address: go to RESP.
  - Legal read: load the latency counter with MEM_LAT and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where it reaches 0, register I_MemRData into the owner's RData and go to RESP.
- RESP (one cycle):
  - Owner's Ack=1; O_AddrErr=1 if the error flag is set.
  - Illegal-address reads return RData=0.
  - Go to IDLE. The non-owner's Ack and RData stay 0.
- Latency, counted from the request first visible in IDLE at cycle 0:
  - Write or error access: Ack in cycle 2.
  - Read: Ack in cycle 2+MEM_LAT.
  - Back-to-back accesses: the next grant is earliest in the IDLE cycle after RESP.
- Requester obligations:
  - Hold Req, We, Addr and WData stable until Ack.
  - Drop Req in the cycle after Ack. Req still high in IDLE after RESP is treated as a new request.
- Request changes in ISSUE/WAIT/RESP are ignored because the fields are captured at grant.
- A request deasserting before its Ack is a protocol violation; the access still completes.
- Simultaneous P and D requests with starvation count < STARVE_MAX: P is served and D waits. D is guaranteed service within STARVE_MAX+1 P accesses.
- Counter and address comparisons are unsigned; MemAddr is the ADDR_W-bit captured address with no truncation.

Test Plan:
- P write 0x3A5C to addr 0x010 alone -> MemEn=1, MemWe=1, MemAddr=0x010 in cycle 1; O_P_Ack in cycle 2; O_P_Stall high in cycles 0–1, low in cycle 2.
- P read of addr 0x010 with memory model returning 0x3A5C, MEM_LAT=2 -> O_P_Ack in cycle 4 with O_P_RData=0x3A5C; O_P_Stall high in cycles 0–3.
- P and D both request writes continuously, STARVE_MAX=4 -> grant order P,P,P,P,D,P,…; D is acked after exactly 4 P accesses; starvation counter reads 0 after the D grant.
- D read at addr 0x400 with MEM_DEPTH=1024 -> MemEn never asserted; O_D_Ack and O_AddrErr in cycle 2; O_D_RData=0x0000.
- I_LOCK pulsed low during WAIT of a P read -> all outputs 0 immediately, no Ack; after release with I_P_Req still high, a fresh read completes normally.
- P changes I_P_Addr during WAIT -> the completed read returns data for the address captured at grant.
